exec_datapath_seq: RTL and testbench
====================================

Name: exec_datapath_seq

Overview:
- Parametrised, sequenced successor to the integrated memory/register-file/ALU/flag datapath of the 16-bit CPU.
- Accepts one operation per start handshake: reads two registers, executes the ALU, optionally loads from data memory, evaluates the condition code against the stored flags, then writes back and updates the flags.
- Sits between the control unit and data memory; its ext write port preloads registers for bring-up and test.

Parameters:
- DATA_W, 16, datapath and register width
- NUM_REGS, 16, register count; address width RA_W = clog2(NUM_REGS)
- MEM_LAT, 1, data-memory read latency in cycles (≥1)

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when ready=1
- ready  out  1  high only in IDLE
- ra1, ra2  in  RA_W  source register addresses
- wa  in  RA_W  destination register
- alu_op  in  3  ALU operation
- src_b  in  1  0: operand B = reg[ra2]; 1: operand B = imm
- imm  in  DATA_W  sign-extended immediate
- lm  in  1  1: result = memory data at the ALU-result address
- fu  in  1  flag update enable
- cc  in  3  condition mask over {N,Z,P}
- mem_addr  out  DATA_W  memory address
- mem_re  out  1  memory read strobe
- mem_rdata  in  DATA_W  memory read data
- ext_we  in  1  external register write; honoured only in IDLE
- ext_wa  in  RA_W  external write address
- ext_wd  in  DATA_W  external write data
- done  out  1  one-cycle pulse in WB
- perform  out  1  condition result, valid while done=1
- result  out  DATA_W  write-back value, valid while done=1
- flags  out  3  current {N,Z,P}

Behaviour:
- Reset (asynchronous, any state):
  - FSM → IDLE; all registers cleared to 0.
  - flags = 3'b010; done = 0, perform = 0, result = 0.
  - mem_re = 0, mem_addr = 0.
- FSM states: IDLE → READ → EXEC → (MEM if lm) → WB → IDLE.
- IDLE:
  - ready = 1.
  - On start, all operation fields are latched; next state READ.
- READ:
  - reg[ra1] and reg[ra2] are latched into operand A/B registers.
  - If src_b = 1, operand B is taken from the latched imm instead.
- EXEC:
  - ALU computes from the operand registers.
  - Op codes: 000 ADD, 001 SUB (A−B), 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 PASS B.
  - Arithmetic is modulo 2^DATA_W; shift amount = B[clog2(DATA_W)-1:0].
  - The ALU result is registered.
  - If lm: mem_addr = ALU result and mem_re = 1 for this cycle only.
- MEM:
  - Lasts exactly MEM_LAT cycles; mem_addr is held.
  - mem_rdata is captured at the edge ending the last MEM cycle.
- WB (one cycle):
  - done = 1; result = captured memory data if lm, else the ALU result.
  - perform = |(cc & flags), evaluated on the flags held before this operation.
  - At the edge ending WB:
    - If perform: reg[wa] ← result.
    - If fu: flags ← {result[MSB], result==0, !result[MSB] && result!=0}. fu does not depend on perform.
- Latency, counting start sampled at edge 0: done is high in cycle 3 (lm=0) or cycle 3+MEM_LAT (lm=1).
- start while not ready: ignored, no queuing.
- ext_we while not IDLE: ignored. ext_we and start together in IDLE: the ext write commits; the operation's READ sees the new value.
- wa == ra1 or wa == ra2: reads return the old value; no forwarding between operations is needed, since operations are serialised.
- cc = 3'b111 always performs; cc = 3'b000 never performs.

Optional Feature:
- Macro EXEC_REG0_ZERO_EN.
- Defined: reg[0] is hardwired to 0; writes to address 0 from WB or ext are discarded; reads of address 0 return 0.
- Undefined: reg[0] is an ordinary register.

Decomposition:
- Package exec_pkg holds:
  - ALU op localparams (ALU_ADD … ALU_PASSB)
  - FSM state enum (S_IDLE, S_READ, S_EXEC, S_MEM, S_WB)
  - flag bit indices (FLG_N=2, FLG_Z=1, FLG_P=0)
- One sub-module, exec_regfile: NUM_REGS×DATA_W, two asynchronous read ports, one synchronous write port with the write mux, EXEC_REG0_ZERO_EN handled inside.
- The ALU stays inline as a combinational case block.

Test Plan:
- Reset then idle → flags=010, ready=1, done=0, every register reads 0.
- ext writes r0=1, r1=0; ADD ra1=0 ra2=1 wa=2, cc=111, fu=1 → done in cycle 3, perform=1, result=0x0001, r2=1, flags=001.
- With flags=001: SUB r1−r0, cc=100, fu=0 → perform=0, result=0xFFFF, r-wa unchanged, flags stay 001.
- lm=1, src_b=1, imm=0x0004, ALU_PASSB, MEM_LAT=2, memory returns 0x001F at address 4 → mem_re pulses in EXEC, mem_addr=0x0004, done in cycle 5, result=0x001F, written if cc=111.
- start pulsed during EXEC of a running op, plus ext_we during MEM → both ignored; exactly one done; no extra register change.
- RST_N asserted during MEM → immediate IDLE, done=0, registers 0, flags=010; next start behaves as from fresh reset.
- With EXEC_REG0_ZERO_EN: ext write r0=0x1234 then ADD r0+r0 → result 0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the sequenced execute datapath: ALU op codes, FSM states, flag bit positions.
package exec_pkg;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b010;
   localparam logic [2:0] ALU_OR    = 3'b011;
   localparam logic [2:0] ALU_XOR   = 3'b100;
   localparam logic [2:0] ALU_SLL   = 3'b101;
   localparam logic [2:0] ALU_SRL   = 3'b110;
   localparam logic [2:0] ALU_PASSB = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_EXEC = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4
   } state_t;

   localparam int FLG_N = 2;
   localparam int FLG_Z = 1;
   localparam int FLG_P = 0;

endpackage

// File: rtl/exec_regfile.sv
// Register file: two asynchronous read ports and one write port muxed between write-back and ext.
// With EXEC_REG0_ZERO_EN defined, r0 reads as zero and ignores writes.
module exec_regfile
   import exec_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 16,
   parameter int RA_W     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [RA_W-1:0]   rd_a1,
   input  logic [RA_W-1:0]   rd_a2,
   output logic [DATA_W-1:0] rd_d1,
   output logic [DATA_W-1:0] rd_d2,
   input  logic              wb_we,
   input  logic [RA_W-1:0]   wb_wa,
   input  logic [DATA_W-1:0] wb_wd,
   input  logic              ext_we,
   input  logic [RA_W-1:0]   ext_wa,
   input  logic [DATA_W-1:0] ext_wd
);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              we;
   logic [RA_W-1:0]   wa;
   logic [DATA_W-1:0] wd;

   // The two writers are never active together (ext only in IDLE, wb only in WB).
   always_comb begin
      we = 1'b0;
      wa = '0;
      wd = '0;
      if (wb_we) begin
         we = 1'b1;
         wa = wb_wa;
         wd = wb_wd;
      end else if (ext_we) begin
         we = 1'b1;
         wa = ext_wa;
         wd = ext_wd;
      end
`ifdef EXEC_REG0_ZERO_EN
      if (wa == '0) we = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (we) begin
         regs[wa] <= wd;
      end
   end

`ifdef EXEC_REG0_ZERO_EN
   assign rd_d1 = (rd_a1 == '0) ? '0 : regs[rd_a1];
   assign rd_d2 = (rd_a2 == '0) ? '0 : regs[rd_a2];
`else
   assign rd_d1 = regs[rd_a1];
   assign rd_d2 = regs[rd_a2];
`endif

endmodule

// File: rtl/exec_datapath_seq.sv
// Sequenced execute datapath: READ -> EXEC -> (MEM) -> WB per accepted operation.
// Build option EXEC_REG0_ZERO_EN makes r0 a hardwired zero (handled in exec_regfile).
module exec_datapath_seq
   import exec_pkg::*;
#(
   parameter  int DATA_W   = 16,
   parameter  int NUM_REGS = 16,
   parameter  int MEM_LAT  = 1,
   localparam int RA_W     = $clog2(NUM_REGS)
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              start,
   output logic              ready,
   input  logic [RA_W-1:0]   ra1,
   input  logic [RA_W-1:0]   ra2,
   input  logic [RA_W-1:0]   wa,
   input  logic [2:0]        alu_op,
   input  logic              src_b,
   input  logic [DATA_W-1:0] imm,
   input  logic              lm,
   input  logic              fu,
   input  logic [2:0]        cc,
   output logic [DATA_W-1:0] mem_addr,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              ext_we,
   input  logic [RA_W-1:0]   ext_wa,
   input  logic [DATA_W-1:0] ext_wd,
   output logic              done,
   output logic              perform,
   output logic [DATA_W-1:0] result,
   output logic [2:0]        flags,
   output state_t            dbg_state
);

   localparam int SH_W  = $clog2(DATA_W);
   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

   state_t            state, next;
   logic [RA_W-1:0]   ra1_q, ra2_q, wa_q;
   logic [2:0]        op_q, cc_q, flags_q;
   logic              src_b_q, lm_q, fu_q;
   logic [DATA_W-1:0] imm_q, opa_q, opb_q, alu_q, mem_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] rd1, rd2, alu_y, wb_val;
   logic [2:0]        new_flags;

   // Handshake: an operation is accepted on a rising edge where start && ready;
   // ready is high only in IDLE and a start seen at any other time is dropped, not queued.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= S_IDLE;
      else        state <= next;
   end

   always_comb begin
      next   = state;
      ready  = 1'b0;
      done   = 1'b0;
      mem_re = 1'b0;
      case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (start) next = S_READ;
         end
         S_READ: next = S_EXEC;
         S_EXEC: begin
            mem_re = lm_q;
            next   = lm_q ? S_MEM : S_WB;
         end
         S_MEM:  if (cnt_q == CNT_LAST) next = S_WB;
         S_WB: begin
            done = 1'b1;
            next = S_IDLE;
         end
         default: next = S_IDLE;
      endcase
   end

   always_comb begin
      alu_y = '0;
      case (op_q)
         ALU_ADD:   alu_y = opa_q + opb_q;
         ALU_SUB:   alu_y = opa_q - opb_q;
         ALU_AND:   alu_y = opa_q & opb_q;
         ALU_OR:    alu_y = opa_q | opb_q;
         ALU_XOR:   alu_y = opa_q ^ opb_q;
         ALU_SLL:   alu_y = opa_q << opb_q[SH_W-1:0];
         ALU_SRL:   alu_y = opa_q >> opb_q[SH_W-1:0];
         ALU_PASSB: alu_y = opb_q;
         default:   alu_y = '0;
      endcase
   end

   assign wb_val = lm_q ? mem_q : alu_q;
   assign new_flags[FLG_N] = wb_val[DATA_W-1];
   assign new_flags[FLG_Z] = (wb_val == '0);
   assign new_flags[FLG_P] = !wb_val[DATA_W-1] && (wb_val != '0);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ra1_q   <= '0;
         ra2_q   <= '0;
         wa_q    <= '0;
         op_q    <= '0;
         cc_q    <= '0;
         src_b_q <= 1'b0;
         lm_q    <= 1'b0;
         fu_q    <= 1'b0;
         imm_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         alu_q   <= '0;
         mem_q   <= '0;
         cnt_q   <= '0;
         flags_q <= 3'b010;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               ra1_q   <= ra1;
               ra2_q   <= ra2;
               wa_q    <= wa;
               op_q    <= alu_op;
               cc_q    <= cc;
               src_b_q <= src_b;
               lm_q    <= lm;
               fu_q    <= fu;
               imm_q   <= imm;
            end
            S_READ: begin
               opa_q <= rd1;
               opb_q <= src_b_q ? imm_q : rd2;
            end
            S_EXEC: begin
               alu_q <= alu_y;
               cnt_q <= '0;
            end
            S_MEM: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) mem_q <= mem_rdata;
            end
            S_WB: if (fu_q) flags_q <= new_flags;
            default: ;
         endcase
      end
   end

   // Address is live combinationally in EXEC so the read strobe and address coincide.
   assign mem_addr  = (state == S_EXEC && lm_q) ? alu_y :
                      (state == S_MEM)          ? alu_q : '0;
   assign perform   = done && |(cc_q & flags_q);
   assign result    = done ? wb_val : '0;
   assign flags     = flags_q;
   assign dbg_state = state;

   exec_regfile #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .RA_W     (RA_W)
   ) u_regfile (
      .clk    (CLK),
      .rst_n  (RST_N),
      .rd_a1  (ra1_q),
      .rd_a2  (ra2_q),
      .rd_d1  (rd1),
      .rd_d2  (rd2),
      .wb_we  (done && perform),
      .wb_wa  (wa_q),
      .wb_wd  (wb_val),
      .ext_we (ext_we && (state == S_IDLE)),
      .ext_wa (ext_wa),
      .ext_wd (ext_wd)
   );

endmodule

// File: tb/tb_exec_datapath_seq.sv
// Directed bench for exec_datapath_seq with a MEM_LAT-deep memory model and hand-computed expectations.
module tb_exec_datapath_seq;
   import exec_pkg::*;

   localparam int MEM_LAT = 2;
`ifdef EXEC_REG0_ZERO_EN
   localparam logic R0Z = 1'b1;
`else
   localparam logic R0Z = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        start = 1'b0;
   logic        ready;
   logic [3:0]  ra1 = '0, ra2 = '0, wa = '0;
   logic [2:0]  alu_op = '0;
   logic        src_b = 1'b0;
   logic [15:0] imm = '0;
   logic        lm = 1'b0, fu = 1'b0;
   logic [2:0]  cc = '0;
   logic [15:0] mem_addr;
   logic        mem_re;
   logic [15:0] mem_rdata;
   logic        ext_we = 1'b0;
   logic [3:0]  ext_wa = '0;
   logic [15:0] ext_wd = '0;
   logic        done, perform;
   logic [15:0] result;
   logic [2:0]  flags;
   state_t      dbg_state;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   exec_datapath_seq #(.DATA_W(16), .NUM_REGS(16), .MEM_LAT(MEM_LAT)) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .ready(ready),
      .ra1(ra1), .ra2(ra2), .wa(wa), .alu_op(alu_op), .src_b(src_b), .imm(imm),
      .lm(lm), .fu(fu), .cc(cc), .mem_addr(mem_addr), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .ext_we(ext_we), .ext_wa(ext_wa), .ext_wd(ext_wd),
      .done(done), .perform(perform), .result(result), .flags(flags),
      .dbg_state(dbg_state)
   );

   // Memory model: data appears MEM_LAT edges after the strobe, garbage otherwise.
   logic [15:0] pipe_d [MEM_LAT];
   logic        pipe_v [MEM_LAT];

   function automatic logic [15:0] mem_fn(input logic [15:0] a);
      return (a == 16'h0004) ? 16'h001F : (a ^ 16'h5A5A);
   endfunction

   always @(posedge CLK) begin
      pipe_v[0] <= mem_re;
      pipe_d[0] <= mem_fn(mem_addr);
      for (int i = 1; i < MEM_LAT; i++) begin
         pipe_v[i] <= pipe_v[i-1];
         pipe_d[i] <= pipe_d[i-1];
      end
   end
   assign mem_rdata = pipe_v[MEM_LAT-1] ? pipe_d[MEM_LAT-1] : 16'hDEAD;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic ext_write(input logic [3:0] a, input logic [15:0] d);
      ext_we = 1'b1; ext_wa = a; ext_wd = d;
      @(posedge CLK); #1;
      ext_we = 1'b0;
   endtask

   // Issues one operation and observes a fixed 14-cycle window; optional start/ext injections.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [3:0] a1,
                         input logic [3:0] a2, input logic [3:0] w, input logic sb,
                         input logic [15:0] im, input logic l, input logic f,
                         input logic [2:0] c, input logic [15:0] exp_res,
                         input logic exp_perf, input logic [15:0] exp_addr,
                         input int inj_start, input int inj_ext);
      int lat = 0, n_done = 0, n_re = 0, re_cyc = 0, waited = 0;
      logic [15:0] res = '0, addr = '0;
      logic perf = 1'b0;
      while (!ready && waited < 20) begin
         @(posedge CLK); #1;
         waited++;
      end
      check({tag, " ready"}, {31'd0, ready}, 32'd1);
      alu_op = op; ra1 = a1; ra2 = a2; wa = w; src_b = sb; imm = im;
      lm = l; fu = f; cc = c; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= 14; cyc++) begin
         if (done) begin
            n_done++;
            if (n_done == 1) begin
               lat = cyc; res = result; perf = perform;
            end
         end
         if (mem_re) begin
            n_re++; re_cyc = cyc; addr = mem_addr;
         end
         start = (cyc == inj_start);
         if (cyc == inj_start) begin
            alu_op = ALU_PASSB; src_b = 1'b1; imm = 16'h0BAD; wa = 4'd10;
            cc = 3'b111; lm = 1'b0; fu = 1'b1;
         end
         ext_we = (cyc == inj_ext); ext_wa = 4'd9; ext_wd = 16'hBEEF;
         @(posedge CLK); #1;
      end
      start = 1'b0; ext_we = 1'b0;
      check({tag, " done_count"}, n_done, 1);
      check({tag, " latency"}, lat, l ? 3 + MEM_LAT : 3);
      check({tag, " result"}, {16'd0, res}, {16'd0, exp_res});
      check({tag, " perform"}, {31'd0, perf}, {31'd0, exp_perf});
      check({tag, " mem_re_count"}, n_re, {31'd0, l});
      if (l) begin
         check({tag, " mem_re_cycle"}, re_cyc, 2);
         check({tag, " mem_addr"}, {16'd0, addr}, {16'd0, exp_addr});
      end
   endtask

   task automatic check_reg(input logic [3:0] r, input logic [15:0] exp);
      run_op($sformatf("r%0d", r), ALU_PASSB, 4'd0, r, 4'd0, 1'b0, 16'd0, 1'b0, 1'b0,
             3'b000, exp, 1'b0, 16'd0, 0, 0);
   endtask

   task automatic add_sub_basic(input string tag);
      logic [15:0] v0;
      v0 = R0Z ? 16'd0 : 16'd1;
      ext_write(4'd0, 16'd1);
      ext_write(4'd1, 16'd0);
      run_op({tag, " add"}, ALU_ADD, 4'd0, 4'd1, 4'd2, 1'b0, 16'd0, 1'b0, 1'b1, 3'b111,
             v0, 1'b1, 16'd0, 0, 0);
      check({tag, " add_flags"}, {29'd0, flags}, R0Z ? 32'd2 : 32'd1);
      check_reg(4'd2, v0);
      run_op({tag, " sub"}, ALU_SUB, 4'd1, 4'd0, 4'd3, 1'b0, 16'd0, 1'b0, 1'b0, 3'b100,
             16'(16'd0 - v0), 1'b0, 16'd0, 0, 0);
      check({tag, " sub_flags"}, {29'd0, flags}, R0Z ? 32'd2 : 32'd1);
      check_reg(4'd3, 16'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge CLK);
      @(negedge CLK); RST_N = 1'b1;
      @(posedge CLK); #1;

      check("rst ready", {31'd0, ready}, 32'd1);
      check("rst done", {31'd0, done}, 32'd0);
      check("rst flags", {29'd0, flags}, 32'd2);
      check("rst result", {16'd0, result}, 32'd0);
      check("rst mem_re", {31'd0, mem_re}, 32'd0);
      check("rst mem_addr", {16'd0, mem_addr}, 32'd0);
      for (int r = 0; r < 16; r++) check_reg(4'(r), 16'd0);
      check("reads keep flags", {29'd0, flags}, 32'd2);

      add_sub_basic("base");

      // Load path: PASS B of imm 4 -> memory returns 0x001F.
      run_op("load", ALU_PASSB, 4'd0, 4'd0, 4'd4, 1'b1, 16'h0004, 1'b1, 1'b1, 3'b111,
             16'h001F, 1'b1, 16'h0004, 0, 0);
      check("load flags", {29'd0, flags}, 32'd1);
      check_reg(4'd4, 16'h001F);

      ext_write(4'd5, 16'hF0F0);
      ext_write(4'd6, 16'h0FF3);
      run_op("and", ALU_AND, 4'd5, 4'd6, 4'd7, 1'b0, 16'd0, 1'b0, 1'b0, 3'b111,
             16'h00F0, 1'b1, 16'd0, 0, 0);
      run_op("or", ALU_OR, 4'd5, 4'd6, 4'd7, 1'b0, 16'd0, 1'b0, 1'b0, 3'b001,
             16'hFFF3, 1'b1, 16'd0, 0, 0);
      run_op("xor", ALU_XOR, 4'd5, 4'd6, 4'd7, 1'b0, 16'd0, 1'b0, 1'b0, 3'b000,
             16'hFF03, 1'b0, 16'd0, 0, 0);
      run_op("add_wrap", ALU_ADD, 4'd5, 4'd6, 4'd7, 1'b0, 16'd0, 1'b0, 1'b0, 3'b010,
             16'h00E3, 1'b0, 16'd0, 0, 0);
      run_op("sll4", ALU_SLL, 4'd5, 4'd0, 4'd7, 1'b1, 16'h0004, 1'b0, 1'b0, 3'b000,
             16'h0F00, 1'b0, 16'd0, 0, 0);
      run_op("srl4", ALU_SRL, 4'd5, 4'd0, 4'd7, 1'b1, 16'h0004, 1'b0, 1'b0, 3'b000,
             16'h0F0F, 1'b0, 16'd0, 0, 0);
      run_op("sll_mask", ALU_SLL, 4'd5, 4'd0, 4'd8, 1'b1, 16'h0013, 1'b0, 1'b1, 3'b111,
             16'h8780, 1'b1, 16'd0, 0, 0);
      check("neg flags", {29'd0, flags}, 32'd4);
      run_op("cc_n", ALU_PASSB, 4'd0, 4'd0, 4'd8, 1'b1, 16'h0005, 1'b0, 1'b0, 3'b100,
             16'h0005, 1'b1, 16'd0, 0, 0);
      check_reg(4'd8, 16'h0005);
      run_op("zero_res", ALU_XOR, 4'd5, 4'd5, 4'd8, 1'b0, 16'd0, 1'b0, 1'b1, 3'b011,
             16'h0000, 1'b0, 16'd0, 0, 0);
      check("zero flags", {29'd0, flags}, 32'd2);
      check_reg(4'd8, 16'h0005);
      check_reg(4'd7, 16'hFFF3);

      // Same-cycle ext write and start: READ must see the new value.
      ext_we = 1'b1; ext_wa = 4'd12; ext_wd = 16'h0007;
      run_op("ext_start", ALU_ADD, 4'd12, 4'd0, 4'd13, 1'b1, 16'h0001, 1'b0, 1'b0, 3'b000,
             16'h0008, 1'b0, 16'd0, 0, 0);
      check_reg(4'd12, 16'h0007);

      // Start during EXEC and ext write during MEM are both ignored.
      run_op("busy_ign", ALU_PASSB, 4'd0, 4'd0, 4'd11, 1'b1, 16'h0004, 1'b1, 1'b0, 3'b111,
             16'h001F, 1'b1, 16'h0004, 2, 3);
      check("busy flags", {29'd0, flags}, 32'd2);
      check_reg(4'd11, 16'h001F);
      check_reg(4'd9, 16'h0000);
      check_reg(4'd10, 16'h0000);

      // Asynchronous reset in the middle of MEM.
      alu_op = ALU_PASSB; src_b = 1'b1; imm = 16'h0004; lm = 1'b1; fu = 1'b1;
      cc = 3'b111; wa = 4'd14; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST_N = 1'b0;
      #1;
      check("mrst ready", {31'd0, ready}, 32'd1);
      check("mrst done", {31'd0, done}, 32'd0);
      check("mrst flags", {29'd0, flags}, 32'd2);
      check("mrst mem_re", {31'd0, mem_re}, 32'd0);
      check("mrst mem_addr", {16'd0, mem_addr}, 32'd0);
      check("mrst result", {16'd0, result}, 32'd0);
      @(negedge CLK); RST_N = 1'b1;
      @(posedge CLK); #1;
      for (int r = 0; r < 16; r++) check_reg(4'(r), 16'd0);
      add_sub_basic("after_rst");

      // r0 behaviour depends on the build option.
      ext_write(4'd0, 16'h1234);
      run_op("r0_add", ALU_ADD, 4'd0, 4'd0, 4'd15, 1'b0, 16'd0, 1'b0, 1'b0, 3'b000,
             R0Z ? 16'h0000 : 16'h2468, 1'b0, 16'd0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
